pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
// - Central stall/flush sequencer for the 5-stage RV32 pipeline; drives the hold and bubble controls that the forwarding path cannot resolve.
// - Resolves four hazards: load-use, EX-stage redirect (branch/jump), multi-cycle MDU op, data-memory wait.
// - Sits beside the forwarding unit. Consumes decode/EX/MEM hazard info and owns the MDU start/done handshake.
// PARAMETERS
// - REG_W    5   register index width
// - CNT_W    32  width of perf counters (PERF_CNT_EN only)
// PORTS
// - clk            in   1      pipeline clock, rising edge
// - rstn           in   1      asynchronous active-low reset
// - rs1_d,rs2_d    in   REG_W  source regs of instr in ID
// - use_rs1_d/rs2_d in  1      ID instr actually reads rs1/rs2
// - rd_e           in   REG_W  dest reg of instr in EX
// - MemRead_e      in   1      EX instr is a load
// - br_taken_e     in   1      EX resolved redirect (taken branch / jal / jalr)
// - mdu_op_e       in   1      EX instr is mul/div
// - mdu_done       in   1      MDU result valid this cycle (1-cycle pulse)
// - mdu_start      out  1      1-cycle start pulse to MDU
// - dmem_req_m     in   1      MEM stage issues a data-memory access
// - dmem_ready_m   in   1      data memory completes access this cycle
// - stall_f,stall_d,stall_e,stall_m  out 1  hold IF/ID/EX/MEM pipeline registers
// - flush_d,flush_e,flush_m,flush_w  out 1  load bubble into ID/EX/MEM/WB registers
// BEHAVIOUR
// - FSM states: RUN, MDU_BUSY. Reset -> RUN. All outputs are 0 in reset and in RUN with all inputs 0.
// - Priority: mem wait > MDU > redirect > load-use. A lower-priority hazard is masked while a higher one is active.
// - Mem wait (comb): dmem_req_m & !dmem_ready_m -> stall_f/d/e/m=1, flush_w=1, every other flush=0. The FSM holds its state.
//   A redirect that arrives during a mem wait stays pending and takes effect on the first unfrozen cycle.
// - MDU, RUN & mdu_op_e & no mem wait:
//   - mdu_start=1 (exactly one cycle). Next state MDU_BUSY.
//   - stall_f/d/e=1, flush_m=1.
// - MDU_BUSY & !mdu_done: stall_f/d/e=1, flush_m=1, mdu_start=0.
// - MDU_BUSY & mdu_done: no stall. The op advances to MEM. Next state RUN.
//   Back-to-back MDU ops therefore restart one cycle later.
// - mdu_done while in RUN is ignored.
// - Redirect (comb): br_taken_e & no higher hazard -> flush_d=1, flush_e=1, no stall. Any load-use stall that cycle is suppressed.
// - Load-use (comb): MemRead_e & rd_e!=0 & ((use_rs1_d & rs1_d==rd_e) | (use_rs2_d & rs2_d==rd_e)).
//   - Action: stall_f=stall_d=1, flush_e=1. Lasts exactly 1 cycle.
//   - Forwarding from MEM covers the following cycle.
// - Latency: all hazard outputs are combinational from the inputs plus state. Only the state register is sequential.
// - Reset mid-MDU: the FSM returns to RUN and mdu_start is not re-issued. The MDU must also reset.
// CONFIGURATION
// - PERF_CNT_EN defined: adds outputs stall_cyc[CNT_W] and flush_cnt[CNT_W].
//   - stall_cyc increments every cycle stall_f=1.
//   - flush_cnt increments on every redirect.
//   - Both reset to 0 and wrap modulo 2^CNT_W.
// - PERF_CNT_EN undefined: no counter logic and no counter ports.
// STRUCTURE
// - Package pipe_ctrl_pkg: ctrl_state_t enum {RUN, MDU_BUSY} and REG_W constant (shared with the forwarding unit).
// - Sub-module load_use_detect: combinational rd/rs compare with x0 masking, reused by future dual-issue decode.
// - Top level: priority mux, FSM, optional perf counters.
// TESTING
// - Load-use: lw x5 in EX with add x6,x5,x7 in ID (rs1_d=5, rd_e=5, MemRead_e=1).
//   Expect stall_f=stall_d=flush_e=1 for 1 cycle, then all 0.
// - x0 load: same as load-use with rd_e=0. Expect no stall.
// - Redirect + load-use same cycle: br_taken_e=1 and load-use condition true.
//   Expect flush_d=flush_e=1, stall_f=0.
// - MDU: mdu_op_e=1, mdu_done pulse 4 cycles after mdu_start.
//   Expect mdu_start high for 1 cycle, stall_e=1 for 4 cycles, state RUN after done.
// - Mem wait during MDU_BUSY: dmem_ready_m=0 for 3 cycles.
//   Expect stall_m=flush_w=1, state held MDU_BUSY, mdu_start stays 0.
// - Async reset: assert rstn=0 mid MDU_BUSY. Outputs 0 immediately, state RUN, counters 0 (PERF_CNT_EN).

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and the
// forwarding unit.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the ID
// instruction. Writes to x0 never create a dependency.
module load_use_detect #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [REG_W-1:0] rd,
    input  logic             mem_read,
    output logic             hit
);

    logic rd_nz;
    logic dep1;
    logic dep2;

    assign rd_nz = |rd;
    assign dep1  = use_rs1 && (rs1 == rd);
    assign dep2  = use_rs2 && (rs2 == rd);
    assign hit   = mem_read && rd_nz && (dep1 || dep2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: mem wait > MDU >
// redirect > load-use. Define PERF_CNT_EN to add stall/flush perf counters.
module pipeline_ctrl #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             MemRead_e,
    input  logic             br_taken_e,
    input  logic             mdu_op_e,
    input  logic             mdu_done,
    output logic             mdu_start,
    input  logic             dmem_req_m,
    input  logic             dmem_ready_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cyc,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    import pipe_ctrl_pkg::*;

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic        mem_wait;
    logic        load_use;
    logic        redirect_fire;

    assign mem_wait = dmem_req_m && !dmem_ready_m;

    load_use_detect #(.REG_W(REG_W)) u_lud (
        .rs1      (rs1_d),
        .rs2      (rs2_d),
        .use_rs1  (use_rs1_d),
        .use_rs2  (use_rs2_d),
        .rd       (rd_e),
        .mem_read (MemRead_e),
        .hit      (load_use)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else       state <= next_state;
    end

    // Outputs are gated by rstn so everything reads 0 while reset is held,
    // even with a stale mdu_op_e still sitting in EX.
    always_comb begin
        next_state    = state;
        mdu_start     = 1'b0;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_m       = 1'b0;
        flush_w       = 1'b0;
        redirect_fire = 1'b0;
        if (rstn) begin
            if (mem_wait) begin
                // Whole front end frozen; a redirect in EX stays put and fires later.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (state == RUN && mdu_op_e) begin
                mdu_start  = 1'b1;
                next_state = MDU_BUSY;
                stall_f    = 1'b1;
                stall_d    = 1'b1;
                stall_e    = 1'b1;
                flush_m    = 1'b1;
            end else if (state == MDU_BUSY && !mdu_done) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else begin
                if (state == MDU_BUSY) next_state = RUN;
                if (br_taken_e) begin
                    flush_d       = 1'b1;
                    flush_e       = 1'b1;
                    redirect_fire = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cyc <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f)       stall_cyc <= stall_cyc + 1'b1;
            if (redirect_fire) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = redirect_fire ^ (CNT_W > 0);
`endif

endmodule
